voice_mixer: RTL and testbench

- Sample source for the I2S output path. Generates one signed 16-bit audio sample per sample period by summing NUM_VOICES sawtooth oscillators.
- Scales and saturates the sum, then pushes the result into the sample FIFO that feeds the I2S transmitter.
- Voice pitch and gate are written by the MIDI note handler through a simple register-write port.
- Runs on MCLK (256 x 44.1 kHz), so the internal divider yields one sample every 256 MCLK cycles.

---
 rtl/voice_mixer.sv | 233 +++++++++++++++++++++++
 tb/tb_voice_mixer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_mixer.sv
// -----------------------------------------------------------------------------
// voice_mixer
//
// Sample source for the I2S output path. Once per sample period it sums
// NUM_VOICES sawtooth oscillators (one voice per clock), scales the sum by an
// arithmetic right shift, saturates it to signed 16 bits and offers it to the
// sample FIFO. If the FIFO is full, the sample is dropped and counted.
//
// Ports
//   MCLK        in   master clock (256 x 44.1 kHz)
//   RESET_N     in   asynchronous active-low reset
//   VOICE_WE    in   one-cycle voice register write strobe
//   VOICE_SEL   in   voice index to write
//   VOICE_ON    in   gate value; 1 sets inc/on, 0 turns voice off and clears phase
//   VOICE_INC   in   phase increment for the selected voice
//   FIFO_FULL   in   sample FIFO full flag, sampled only in WRITE
//   AUDIO       out  signed sample presented to the FIFO write data
//   FIFO_WRITE  out  one-cycle FIFO write strobe
//   DROP_COUNT  out  dropped-sample count, saturating at 255
//   BUSY        out  high whenever the state machine is not IDLE
// -----------------------------------------------------------------------------
module voice_mixer #(
    parameter int  NUM_VOICES = 8,
    parameter int  PHASE_W    = 24,
    parameter int  DIV        = 256,
    parameter int  VOL_SHIFT  = 3,
    localparam int SEL_W      = $clog2(NUM_VOICES)
) (
    input  logic                      MCLK,
    input  logic                      RESET_N,
    input  logic                      VOICE_WE,
    input  logic [SEL_W-1:0]          VOICE_SEL,
    input  logic                      VOICE_ON,
    input  logic [PHASE_W-1:0]        VOICE_INC,
    input  logic                      FIFO_FULL,
    output logic signed [15:0]        AUDIO,
    output logic                      FIFO_WRITE,
    output logic [7:0]                DROP_COUNT,
    output logic                      BUSY
);

    // Accumulator holds the full sum of NUM_VOICES signed 16-bit values
    // plus one guard bit.
    localparam int ACC_W = 16 + SEL_W + 1;
    localparam int DIV_W = $clog2(DIV);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Scale the accumulated sum and clamp it into the signed 16-bit range.
    function automatic logic signed [15:0] scale_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] scaled;
        scaled = acc >>> VOL_SHIFT;
        if (scaled > SAT_MAX) begin
            return 16'sh7FFF;
        end else if (scaled < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return scaled[15:0];
        end
    endfunction

    logic [DIV_W-1:0]          divider_q, divider_d;
    state_t                    state_q, state_d;
    logic [SEL_W-1:0]          idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [15:0]        audio_q, audio_d;
    logic [7:0]                drop_q, drop_d;
    logic                      fifo_write_s;
    logic                      tick_s;
    logic signed [15:0]        voice_sample_s;
    logic signed [ACC_W-1:0]   voice_ext_s;

    logic [PHASE_W-1:0]        phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]        phase_d [NUM_VOICES];
    logic [PHASE_W-1:0]        inc_q   [NUM_VOICES];
    logic [PHASE_W-1:0]        inc_d   [NUM_VOICES];
    logic [NUM_VOICES-1:0]     on_q, on_d;

    // Sample-period divider: free-running, wraps at DIV-1 and ticks there.
    always_comb begin
        divider_d = divider_q;
        tick_s    = 1'b0;
        if (divider_q == DIV_W'(DIV - 1)) begin
            divider_d = '0;
            tick_s    = 1'b1;
        end else begin
            divider_d = divider_q + DIV_W'(1);
            tick_s    = 1'b0;
        end
    end

    // Divider register.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            divider_q <= '0;
        end else begin
            divider_q <= divider_d;
        end
    end

    // Top 16 phase bits of the voice being accumulated, sign-extended to the
    // accumulator width.
    always_comb begin
        voice_sample_s = phase_q[idx_q][PHASE_W-1 -: 16];
        voice_ext_s    = {{(ACC_W-16){voice_sample_s[15]}}, voice_sample_s};
    end

    // Sample state machine: next state, accumulator, output sample and drops.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        audio_d      = audio_q;
        drop_d       = drop_q;
        fifo_write_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                // Uses the registered on/phase, so a same-cycle voice write
                // cannot disturb this voice's contribution.
                if (on_q[idx_q]) begin
                    acc_d = acc_q + voice_ext_s;
                end else begin
                    acc_d = acc_q;
                end
                if (idx_q == SEL_W'(NUM_VOICES - 1)) begin
                    state_d = ST_SAT;
                end else begin
                    idx_d   = idx_q + SEL_W'(1);
                    state_d = ST_ACCUM;
                end
            end
            ST_SAT: begin
                audio_d = scale_sat(acc_q);
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (!FIFO_FULL) begin
                    fifo_write_s = 1'b1;
                end else if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end else begin
                    drop_d = drop_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State machine and datapath registers.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            audio_q <= 16'sd0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            audio_q <= audio_d;
            drop_q  <= drop_d;
        end
    end

    // Voice registers: phase advance for the accumulated voice plus host writes.
    // A write's on/inc always win; a gate-off write clears phase and overrides
    // any advance happening in the same cycle.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (VOICE_WE && (VOICE_SEL == SEL_W'(v)) && !VOICE_ON) begin
                phase_d[v] = '0;
            end else if ((state_q == ST_ACCUM) && (idx_q == SEL_W'(v)) && on_q[v]) begin
                phase_d[v] = phase_q[v] + inc_q[v];
            end else begin
                phase_d[v] = phase_q[v];
            end

            if (VOICE_WE && (VOICE_SEL == SEL_W'(v))) begin
                on_d[v]  = VOICE_ON;
                inc_d[v] = VOICE_ON ? VOICE_INC : inc_q[v];
            end else begin
                on_d[v]  = on_q[v];
                inc_d[v] = inc_q[v];
            end
        end
    end

    // Voice register storage.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= '0;
                inc_q[v]   <= '0;
            end
            on_q <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_q[v] <= phase_d[v];
                inc_q[v]   <= inc_d[v];
            end
            on_q <= on_d;
        end
    end

    // The strobe is decoded from the WRITE state so that FIFO_FULL, sampled in
    // that same cycle, gates it directly.
    assign FIFO_WRITE = fifo_write_s;
    assign AUDIO      = audio_q;
    assign DROP_COUNT = drop_q;
    assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_voice_mixer.sv
// -----------------------------------------------------------------------------
// tb_voice_mixer
//
// Directed bench for voice_mixer. Two instances share all inputs: one with the
// default VOL_SHIFT=3, one with VOL_SHIFT=0 to reach saturation. A behavioural
// model of the voices computes each sample's raw sum on the tick cycle and
// queues it with its due cycle; the per-cycle checker pops and compares.
// -----------------------------------------------------------------------------
module tb_voice_mixer;

    logic                mclk;
    logic                rst_n;
    logic                voice_we;
    logic [2:0]          voice_sel;
    logic                voice_on;
    logic [23:0]         voice_inc;
    logic                fifo_full;
    logic signed [15:0]  audio, audio_s0;
    logic                fifo_write, fifo_write_s0;
    logic [7:0]          drop_count, drop_count_s0;
    logic                busy, busy_s0;

    typedef struct {
        int due;
        int sum;
    } exp_t;

    exp_t        exp_q [$];
    logic [23:0] m_phase [8];
    logic [23:0] m_inc   [8];
    logic        m_on    [8];
    int          m_drop;
    int          cyc;
    int          checks;
    int          failures;
    int          wr_count;
    int          last_write_cyc;
    int          last_a3;
    int          last_a0;

    voice_mixer u_dut (
        .MCLK       (mclk),
        .RESET_N    (rst_n),
        .VOICE_WE   (voice_we),
        .VOICE_SEL  (voice_sel),
        .VOICE_ON   (voice_on),
        .VOICE_INC  (voice_inc),
        .FIFO_FULL  (fifo_full),
        .AUDIO      (audio),
        .FIFO_WRITE (fifo_write),
        .DROP_COUNT (drop_count),
        .BUSY       (busy)
    );

    voice_mixer #(.VOL_SHIFT(0)) u_dut_s0 (
        .MCLK       (mclk),
        .RESET_N    (rst_n),
        .VOICE_WE   (voice_we),
        .VOICE_SEL  (voice_sel),
        .VOICE_ON   (voice_on),
        .VOICE_INC  (voice_inc),
        .FIFO_FULL  (fifo_full),
        .AUDIO      (audio_s0),
        .FIFO_WRITE (fifo_write_s0),
        .DROP_COUNT (drop_count_s0),
        .BUSY       (busy_s0)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Cycle number since reset release; cycle k is the period in which the
    // divider reads k mod 256.
    always @(posedge mclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic signed [15:0] clamp16(input int v);
        if (v > 32767)       return 16'sh7FFF;
        else if (v < -32768) return 16'sh8000;
        else                 return 16'(v);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int v = 0; v < 8; v++) begin
            m_phase[v] = 24'h0;
            m_inc[v]   = 24'h0;
            m_on[v]    = 1'b0;
        end
        m_drop = 0;
    endtask

    // Advance to the next falling edge, check that cycle's outputs and run the
    // model's tick when the sample period ends.
    task automatic step();
        exp_t e;
        logic exp_busy;
        logic due;
        logic exp_wr;
        int   sum;
        @(negedge mclk);
        if (rst_n) begin
            exp_busy = (cyc >= 256) && ((cyc % 256) < 10);
            chk("busy", busy, exp_busy);
            chk("busy_s0", busy_s0, exp_busy);
            due    = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            exp_wr = due && !fifo_full;
            chk("fifo_write", fifo_write, exp_wr);
            chk("fifo_write_s0", fifo_write_s0, exp_wr);
            chk("drop_count", drop_count, m_drop);
            chk("drop_count_s0", drop_count_s0, m_drop);
            if (fifo_write) begin
                wr_count++;
                last_write_cyc = cyc;
                last_a3 = int'(audio);
                last_a0 = int'(audio_s0);
            end
            if (due) begin
                e = exp_q.pop_front();
                if (!fifo_full) begin
                    chk("audio", audio, clamp16(e.sum >>> 3));
                    chk("audio_s0", audio_s0, clamp16(e.sum));
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            if ((cyc % 256) == 255) begin
                sum = 0;
                for (int v = 0; v < 8; v++) begin
                    if (m_on[v]) begin
                        sum += int'($signed(m_phase[v][23:8]));
                        m_phase[v] = m_phase[v] + m_inc[v];
                    end
                end
                exp_q.push_back('{due: cyc + 10, sum: sum});
            end
        end
    endtask

    task automatic vwrite(input int sel, input logic on, input logic [23:0] inc);
        voice_we  = 1'b1;
        voice_sel = 3'(sel);
        voice_on  = on;
        voice_inc = inc;
        if (on) begin
            m_on[sel]  = 1'b1;
            m_inc[sel] = inc;
        end else begin
            m_on[sel]    = 1'b0;
            m_phase[sel] = 24'h0;
        end
        step();
        voice_we = 1'b0;
    endtask

    task automatic wait_mod(input int m);
        for (int i = 0; i < 300; i++) begin
            step();
            if ((cyc % 256) == m) return;
        end
        chk("wait_mod_timeout", cyc % 256, m);
    endtask

    // Cycle 20 of a period: the previous sample is written and the next tick
    // is far away, so inputs may change freely.
    task automatic next_idle();
        wait_mod(20);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    int base;
    int p;

    initial begin
        checks = 0; failures = 0; wr_count = 0; last_write_cyc = -1;
        last_a3 = 0; last_a0 = 0;
        voice_we = 1'b0; voice_sel = 3'd0; voice_on = 1'b0;
        voice_inc = 24'h0; fifo_full = 1'b0;
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge mclk);
        chk("rst_audio", audio, 16'sd0);
        chk("rst_fifo_write", fifo_write, 1'b0);
        chk("rst_drop", drop_count, 8'd0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Idle mixer: silent samples at 265, then every 256 cycles.
        next_idle();
        chk("t1_no_write_yet", wr_count, 0);
        next_idle();
        chk("t1_first_write_count", wr_count, 1);
        chk("t1_first_write_cycle", last_write_cyc, 265);
        chk("t1_first_audio", last_a3, 0);
        next_idle();
        chk("t1_second_write_cycle", last_write_cyc, 521);

        // Single sawtooth: top slice steps 0x0800 per sample, so >>>3 gives
        // 256 per sample and wraps to -4096 after 16 samples.
        vwrite(0, 1'b1, 24'h080000);
        for (int k = 0; k < 17; k++) begin
            next_idle();
            chk("t2_saw_s3", last_a3, (k == 16) ? -4096 : k * 256);
            chk("t2_saw_s0", last_a0, (k == 16) ? -32768 : k * 2048);
        end

        // All voices near full scale: positive saturation without shift.
        for (int v = 0; v < 8; v++) vwrite(v, 1'b0, 24'h0);
        for (int v = 0; v < 8; v++) vwrite(v, 1'b1, 24'h7FFF00);
        next_idle();
        chk("t3_pos_s0_0", last_a0, 0);
        next_idle();
        chk("t3_pos_s0_1", last_a0, 32767);
        chk("t3_pos_s3_1", last_a3, 32767);

        // Half-scale increment: alternates 0 and negative full scale.
        for (int v = 0; v < 8; v++) vwrite(v, 1'b0, 24'h0);
        for (int v = 0; v < 8; v++) vwrite(v, 1'b1, 24'h800000);
        for (int k = 0; k < 4; k++) begin
            next_idle();
            chk("t3_neg_s0", last_a0, (k % 2 == 1) ? -32768 : 0);
            chk("t3_neg_s3", last_a3, (k % 2 == 1) ? -32768 : 0);
        end

        // FIFO full: samples dropped and counted while phases keep moving.
        for (int v = 0; v < 8; v++) vwrite(v, 1'b0, 24'h0);
        vwrite(0, 1'b1, 24'h080000);
        fifo_full = 1'b1;
        base = wr_count;
        repeat (3) next_idle();
        chk("t4_no_writes", wr_count, base);
        chk("t4_drop3", drop_count, 8'd3);
        fifo_full = 1'b0;
        next_idle();
        chk("t4_phase_advanced", last_a3, 768);
        fifo_full = 1'b1;
        repeat (253) next_idle();
        chk("t4_drop_sat", drop_count, 8'd255);
        fifo_full = 1'b0;

        // Gate-off written while voice 0 is being accumulated.
        next_idle();
        p = last_a3;
        wait_mod(0);
        vwrite(0, 1'b0, 24'h0);
        next_idle();
        chk("t5_collision_sample", last_a3, (p == 3840) ? -4096 : p + 256);
        next_idle();
        chk("t5_voice_excluded", last_a3, 0);
        vwrite(0, 1'b1, 24'h080000);
        next_idle();
        chk("t5_restart_0", last_a3, 0);
        next_idle();
        chk("t5_restart_1", last_a3, 256);

        // Reset in the middle of accumulation.
        wait_mod(3);
        chk("t6_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_audio", audio, 16'sd0);
        chk("t6_fifo_write", fifo_write, 1'b0);
        chk("t6_drop", drop_count, 8'd0);
        chk("t6_busy", busy, 1'b0);
        base = wr_count;
        do_reset();
        next_idle();
        chk("t6_no_write_yet", wr_count, base);
        next_idle();
        chk("t6_first_write_cycle", last_write_cyc, 265);
        chk("t6_first_audio", last_a3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
